// File: rtl/cam_cfg_sequencer.sv
// Camera register-init sequencer: walks a synchronous ROM of {addr,data}
// entries and issues one SCCB write per entry, with delay and end markers.
//
// Ports:
//   i_sysclk, i_rstn         clock, synchronous active-low reset
//   i_start                  one-cycle start pulse, honoured only when idle
//   o_rom_addr / i_rom_data  ROM read port (data one cycle after address)
//   o_wr_valid / i_wr_ready  SCCB write handshake
//   o_wr_addr / o_wr_data    SCCB register address and data
//   i_sccb_done/i_sccb_nack  write-complete pulse and its NACK qualifier
//   o_busy / o_done / o_err  sequence status (done is a level, err sticky)
module cam_cfg_sequencer #(
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned DELAY_CYCLES   = 250_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter logic [15:0] END_MARK       = 16'hFFFF,
  parameter logic [15:0] DELAY_MARK     = 16'hFFF0
) (
  input  logic              i_sysclk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [7:0]        o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // Delay counts down from N-1 to 0 so DELAY lasts exactly N cycles.
  localparam logic [DW-1:0] DLY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE,
    S_WAIT,
    S_DELAY,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_wr_valid;
  logic [7:0]        r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [DW-1:0]     r_dly_cnt;
  logic [TW-1:0]     r_to_cnt;

  state_t            w_state;
  logic [ROM_AW-1:0] w_rom_addr;
  logic              w_wr_valid;
  logic [7:0]        w_wr_addr;
  logic [7:0]        w_wr_data;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic [DW-1:0]     w_dly_cnt;
  logic [TW-1:0]     w_to_cnt;

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dly_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_rom_addr <= w_rom_addr;
      r_wr_valid <= w_wr_valid;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_dly_cnt  <= w_dly_cnt;
      r_to_cnt   <= w_to_cnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_rom_addr = r_rom_addr;
    w_wr_valid = r_wr_valid;
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;
    w_busy     = r_busy;
    w_done     = r_done;
    w_err      = r_err;
    w_dly_cnt  = r_dly_cnt;
    w_to_cnt   = r_to_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state    = S_FETCH;
          w_rom_addr = '0;
          w_busy     = 1'b1;
          w_done     = 1'b0;
          w_err      = 1'b0;
        end
      end

      // ROM data for the new address lands during this cycle.
      S_FETCH: begin
        w_state = S_DECODE;
      end

      S_DECODE: begin
        if (i_rom_data == END_MARK) begin
          w_state = S_FINISH;
        end else if (i_rom_data == DELAY_MARK) begin
          w_dly_cnt = DLY_LOAD;
          w_state   = S_DELAY;
        end else begin
          w_wr_addr  = i_rom_data[15:8];
          w_wr_data  = i_rom_data[7:0];
          w_wr_valid = 1'b1;
          w_state    = S_WRITE;
        end
      end

      S_WRITE: begin
        if (i_wr_ready) begin
          w_wr_valid = 1'b0;
          w_to_cnt   = '0;
          w_state    = S_WAIT;
        end
      end

      // A done in the last allowed cycle wins over the timeout.
      S_WAIT: begin
        if (i_sccb_done) begin
          if (i_sccb_nack) begin
            w_err = 1'b1;
          end
          w_state = S_NEXT;
        end else if (r_to_cnt == TO_LAST) begin
          w_err   = 1'b1;
          w_state = S_FINISH;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
      end

      S_DELAY: begin
        if (r_dly_cnt == '0) begin
          w_state = S_NEXT;
        end else begin
          w_dly_cnt = r_dly_cnt - 1'b1;
        end
      end

      // Running off the top of the ROM ends the sequence; no wrap.
      S_NEXT: begin
        if (r_rom_addr == ADDR_LAST) begin
          w_state = S_FINISH;
        end else begin
          w_rom_addr = r_rom_addr + 1'b1;
          w_state    = S_FETCH;
        end
      end

      S_FINISH: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_rom_addr = r_rom_addr;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a small ROM and SCCB responder.
// DUT built with ROM_AW=2, DELAY_CYCLES=100, TIMEOUT_CYCLES=64.
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [1:0]  o_rom_addr;
  logic [15:0] rom_q;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [7:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        i_sccb_done;
  logic        i_sccb_nack;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  logic [15:0] rom [0:3];
  logic [15:0] wlog [$];
  int          total = 0;
  int          bad = 0;
  int          done_dly = 1;
  int          nack_idx = -1;

  always #5 clk = ~clk;

  cam_cfg_sequencer #(
    .ROM_AW(2),
    .DELAY_CYCLES(100),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_sysclk(clk),
    .i_rstn(i_rstn),
    .i_start(i_start),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(rom_q),
    .o_wr_valid(o_wr_valid),
    .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .i_sccb_done(i_sccb_done),
    .i_sccb_nack(i_sccb_nack),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err)
  );

  always @(posedge clk) rom_q <= rom[o_rom_addr];

  // SCCB slave: log each accepted write, pulse done done_dly edges later.
  initial begin
    i_sccb_done = 1'b0;
    i_sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (o_wr_valid && i_wr_ready) begin
        wlog.push_back({o_wr_addr, o_wr_data});
        @(posedge clk);
        if (done_dly != 0) begin
          repeat (done_dly - 1) @(posedge clk);
          #1;
          i_sccb_done = 1'b1;
          i_sccb_nack = (nack_idx == wlog.size() - 1);
          @(posedge clk);
          #1;
          i_sccb_done = 1'b0;
          i_sccb_nack = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!o_done && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(o_done), 32'd1);
  endtask

  initial begin
    i_rstn     = 1'b0;
    i_start    = 1'b0;
    i_wr_ready = 1'b0;
    rom[0] = 16'h1280;
    rom[1] = 16'h1101;
    rom[2] = 16'hFFFF;
    rom[3] = 16'h0000;

    // reset values
    step(3);
    chk("rst_valid", 32'(o_wr_valid), 0);
    chk("rst_addr", 32'(o_wr_addr), 0);
    chk("rst_data", 32'(o_wr_data), 0);
    chk("rst_romaddr", 32'(o_rom_addr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    i_rstn = 1'b1;
    step(2);

    // basic two writes, done 3 cycles after accept
    i_wr_ready = 1'b1;
    done_dly   = 3;
    start_pulse();
    chk("t1_busy", 32'(o_busy), 1);
    chk("t1_romaddr", 32'(o_rom_addr), 0);
    wait_done(100, "t1_done");
    chk("t1_nwr", wlog.size(), 2);
    chk("t1_wr0", 32'(wlog[0]), 32'h1280);
    chk("t1_wr1", 32'(wlog[1]), 32'h1101);
    chk("t1_busy_end", 32'(o_busy), 0);
    chk("t1_err", 32'(o_err), 0);
    step(3);
    chk("t1_done_hold", 32'(o_done), 1);

    // ready held low for 20 cycles on the first write
    wlog.delete();
    rom[0] = 16'h2233;
    rom[1] = 16'h4455;
    i_wr_ready = 1'b0;
    done_dly   = 1;
    start_pulse();
    chk("t2_done_clr", 32'(o_done), 0);
    step(2);
    chk("t2_valid", 32'(o_wr_valid), 1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t2_hold_valid", 32'(o_wr_valid), 1);
      chk("t2_hold_ad", 32'({o_wr_addr, o_wr_data}), 32'h2233);
    end
    i_wr_ready = 1'b1;
    step(1);
    chk("t2_drop", 32'(o_wr_valid), 0);
    wait_done(100, "t2_done");
    chk("t2_nwr", wlog.size(), 2);
    chk("t2_wr0", 32'(wlog[0]), 32'h2233);
    chk("t2_wr1", 32'(wlog[1]), 32'h4455);

    // delay entry: first valid 105 cycles after the start edge
    wlog.delete();
    rom[0] = 16'hFFF0;
    rom[1] = 16'h3A04;
    rom[2] = 16'hFFFF;
    start_pulse();
    step(104);
    chk("t3_early", 32'(o_wr_valid), 0);
    step(1);
    chk("t3_valid", 32'(o_wr_valid), 1);
    chk("t3_ad", 32'({o_wr_addr, o_wr_data}), 32'h3A04);
    wait_done(100, "t3_done");
    chk("t3_nwr", wlog.size(), 1);

    // NACK on first of two writes
    wlog.delete();
    rom[0] = 16'h5501;
    rom[1] = 16'h5602;
    nack_idx = 0;
    done_dly = 2;
    start_pulse();
    wait_done(100, "t4_done");
    chk("t4_err", 32'(o_err), 1);
    chk("t4_nwr", wlog.size(), 2);
    chk("t4_wr1", 32'(wlog[1]), 32'h5602);
    step(5);
    chk("t4_err_sticky", 32'(o_err), 1);
    nack_idx = -1;
    wlog.delete();
    start_pulse();
    chk("t4_err_clr", 32'(o_err), 0);
    wait_done(100, "t4_done2");
    chk("t4_err2", 32'(o_err), 0);

    // timeout: accept at E3, err at E67, done at E68
    wlog.delete();
    rom[0] = 16'h7788;
    rom[1] = 16'h99AA;
    done_dly = 0;
    start_pulse();
    step(19);
    start_pulse();
    chk("t5_ign_valid", 32'(o_wr_valid), 0);
    chk("t5_ign_busy", 32'(o_busy), 1);
    step(46);
    chk("t5_err_early", 32'(o_err), 0);
    chk("t5_busy", 32'(o_busy), 1);
    step(1);
    chk("t5_err", 32'(o_err), 1);
    chk("t5_done_early", 32'(o_done), 0);
    step(1);
    chk("t5_done", 32'(o_done), 1);
    chk("t5_busy_end", 32'(o_busy), 0);
    step(20);
    chk("t5_nwr", wlog.size(), 1);
    chk("t5_valid", 32'(o_wr_valid), 0);

    // reset asserted while in WRITE
    wlog.delete();
    rom[0] = 16'h1234;
    rom[1] = 16'h5678;
    i_wr_ready = 1'b0;
    done_dly   = 1;
    start_pulse();
    step(2);
    chk("t6_valid", 32'(o_wr_valid), 1);
    step(3);
    i_rstn = 1'b0;
    step(1);
    chk("t6_valid0", 32'(o_wr_valid), 0);
    chk("t6_addr0", 32'(o_wr_addr), 0);
    chk("t6_data0", 32'(o_wr_data), 0);
    chk("t6_busy0", 32'(o_busy), 0);
    chk("t6_done0", 32'(o_done), 0);
    chk("t6_err0", 32'(o_err), 0);
    chk("t6_rom0", 32'(o_rom_addr), 0);
    i_rstn     = 1'b1;
    i_wr_ready = 1'b1;
    step(20);
    chk("t6_nwr", wlog.size(), 0);
    chk("t6_idle_valid", 32'(o_wr_valid), 0);

    // no end marker: four writes at 5 cycles each, no wrap
    wlog.delete();
    rom[0] = 16'h0101;
    rom[1] = 16'h0202;
    rom[2] = 16'h0303;
    rom[3] = 16'h0404;
    start_pulse();
    step(20);
    chk("t7_done_early", 32'(o_done), 0);
    chk("t7_busy", 32'(o_busy), 1);
    step(1);
    chk("t7_done", 32'(o_done), 1);
    chk("t7_busy_end", 32'(o_busy), 0);
    chk("t7_romaddr", 32'(o_rom_addr), 3);
    chk("t7_nwr", wlog.size(), 4);
    chk("t7_wr0", 32'(wlog[0]), 32'h0101);
    chk("t7_wr3", 32'(wlog[3]), 32'h0404);
    step(10);
    chk("t7_nwr_after", wlog.size(), 4);
    chk("t7_romaddr_after", 32'(o_rom_addr), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
Walks a camera register-initialisation ROM when sys_control pulses its configuration start on i_start. Each 16-bit ROM entry {reg_addr[15:8], reg_data[7:0]} becomes one SCCB write to the downstream SCCB master, with in-ROM delay entries and an end marker. The block reports busy/done/error, which feed the status LEDs and gate pipeline start-up.

Parameters:
ROM_AW, 8, ROM address width; ROM depth = 2**ROM_AW entries
DELAY_CYCLES, 250_000, i_sysclk cycles per delay entry (10 ms at 25 MHz)
TIMEOUT_CYCLES, 50_000, max cycles from write acceptance to i_sccb_done before error
END_MARK, 16'hFFFF, ROM entry that terminates the sequence
DELAY_MARK, 16'hFFF0, ROM entry that inserts one DELAY_CYCLES wait

Ports:
i_sysclk  input  1  system clock
i_rstn  input  1  synchronous active-low reset
i_start  input  1  one-cycle start pulse (from sys_control o_cfg_start)
o_rom_addr  output  ROM_AW  ROM read address, registered
i_rom_data  input  16  ROM read data, valid one cycle after o_rom_addr changes (synchronous ROM)
o_wr_valid  output  1  SCCB write request valid
i_wr_ready  input  1  SCCB master can accept a write
o_wr_addr  output  8  SCCB register address
o_wr_data  output  8  SCCB register data
i_sccb_done  input  1  one-cycle pulse: current write finished
i_sccb_nack  input  1  qualifies i_sccb_done: slave NACKed
o_busy  output  1  sequence in progress
o_done  output  1  sequence completed, level
o_err  output  1  sticky error (NACK or timeout)

Behaviour:
- Reset values: o_rom_addr=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0, all counters=0, state=IDLE.
- Reset mid-operation aborts immediately. o_wr_valid drops on the next edge. No further writes are issued.
- States:
  - IDLE: on i_start, go to FETCH, set o_rom_addr=0, o_busy=1, clear o_done and o_err.
  - FETCH: one-cycle wait for ROM latency, then go to DECODE.
  - DECODE: sample i_rom_data.
    - ==END_MARK: go to FINISH.
    - ==DELAY_MARK: load delay counter, go to DELAY.
    - otherwise: register o_wr_addr/o_wr_data, assert o_wr_valid, go to WRITE.
  - WRITE: hold o_wr_valid, addr and data stable until the cycle where o_wr_valid&&i_wr_ready. On that edge, drop o_wr_valid, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE: the timeout counter increments each cycle.
    - On i_sccb_done: if i_sccb_nack, set o_err. Then go to NEXT.
    - If the counter reaches TIMEOUT_CYCLES-1 without done: set o_err, go to FINISH.
  - DELAY: count down DELAY_CYCLES cycles exactly, then go to NEXT.
  - NEXT: if o_rom_addr == 2**ROM_AW-1, go to FINISH (implicit end, no wrap). Else o_rom_addr+1, go to FETCH.
  - FINISH: o_busy=0, o_done=1, go to IDLE.
- o_done holds until the next accepted i_start.
- i_start while o_busy=1 is ignored. i_start in IDLE after done restarts from address 0.
- A NACK does not abort the sequence; the remaining entries are still written.
- Timeout aborts the sequence. o_done=1 is still raised with o_err=1, so sys_control can proceed and flag the error.
- i_sccb_done outside WAIT_DONE is ignored.
- Minimum cycles per write entry with ready=1 and done on the next cycle: FETCH, DECODE, WRITE, WAIT_DONE, NEXT = 5 cycles.
- The delay counter is wide enough for DELAY_CYCLES. The timeout counter is wide enough for TIMEOUT_CYCLES.

Test Plan:
- ROM [0]=16'h1280, [1]=16'h1101, [2]=FFFF; i_wr_ready=1, done 3 cycles after accept -> writes (12,80) then (11,01), o_done=1, o_busy=0, o_err=0, no third write.
- i_wr_ready held low 20 cycles on the first write -> o_wr_valid held; addr/data stable throughout; exactly one acceptance once ready rises.
- ROM [0]=FFF0, [1]=16'h3A04, [2]=FFFF with DELAY_CYCLES=100 -> first o_wr_valid rises exactly 100 cycles + fixed state overhead after i_start; write (3A,04).
- NACK on the first of two writes -> o_err=1 sticky; second write still issued; o_done=1. Next i_start clears o_err.
- No i_sccb_done with TIMEOUT_CYCLES=64 -> o_err=1 and o_done=1 at 64 cycles after acceptance; no further writes. Second i_start while busy is ignored; i_rstn low mid-WRITE returns all outputs to 0.
- ROM_AW=2 with no end marker (4 write entries) -> 4 writes, then o_done=1; o_rom_addr does not wrap to 0.
